// File: rtl/temporizador_intervalos.sv
// Interval timer with a programmable base/extension/yellow duration table.
// Define TEMPORIZADOR_FAST_SIM_EN to drop the prescaler (one "second" per clock).
module temporizador_intervalos #(
   parameter int unsigned DIV    = 50_000_000,
   parameter logic [3:0]  T_BASE = 4'd6,
   parameter logic [3:0]  T_EXT  = 4'd3,
   parameter logic [3:0]  T_YEL  = 4'd2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_timer,
   input  logic [1:0] intervalo,
   input  logic       prog_we,
   input  logic [1:0] prog_sel,
   input  logic [3:0] prog_value,
   output logic       time_expired,
   output logic [3:0] tiempo_restante,
   output logic       reprogramSincronico
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t     state_q, state_d;
   logic       start_prev_q;
   logic [3:0] count_q, count_d;
   logic [3:0] tr_q, tr_d;
   logic       te_q, te_d;
   logic       rp_q, rp_d;
   logic [3:0] base_q, base_d, ext_q, ext_d, yel_q, yel_d;
   logic       tick;

`ifdef TEMPORIZADOR_FAST_SIM_EN
   assign tick = 1'b1;
`else
   localparam int unsigned PW = $clog2(DIV);
   logic [PW-1:0] presc_q, presc_d;

   assign tick = (presc_q == PW'(DIV - 1));

   // Held at zero outside RUN, so every run starts from a cleared prescaler.
   always_comb begin
      presc_d = '0;
      if (state_q == RUN)
         presc_d = tick ? '0 : presc_q + PW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) presc_q <= '0;
      else       presc_q <= presc_d;
   end
`endif

   logic       wr, rise;
   logic [3:0] wval, sel_dur;

   assign wr   = prog_we & (prog_sel != 2'b11);
   assign rise = start_timer & ~start_prev_q;
   assign wval = (prog_value == 4'd0) ? 4'd1 : prog_value;

   always_comb begin
      case (intervalo)
         2'b01:   sel_dur = ext_q;
         2'b10:   sel_dur = yel_q;
         default: sel_dur = base_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      base_d  = base_q;
      ext_d   = ext_q;
      yel_d   = yel_q;
      rp_d    = wr;
      if (wr) begin
         // A table write overrides any run or rise on the same edge.
         state_d = IDLE;
         count_d = '0;
         case (prog_sel)
            2'b00:   base_d = wval;
            2'b01:   ext_d  = wval;
            default: yel_d  = wval;
         endcase
      end else begin
         case (state_q)
            IDLE: begin
               if (rise) begin
                  count_d = sel_dur;
                  state_d = RUN;
               end
            end
            RUN: begin
               if (!start_timer)
                  state_d = IDLE;
               else if (tick) begin
                  if (count_q == 4'd1) state_d = DONE;
                  else                 count_d = count_q - 4'd1;
               end
            end
            DONE: begin
               if (!start_timer) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
      te_d = (state_d == DONE);
      tr_d = (state_d == RUN) ? count_d : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         start_prev_q <= 1'b0;
         count_q      <= '0;
         tr_q         <= '0;
         te_q         <= 1'b0;
         rp_q         <= 1'b0;
         base_q       <= T_BASE;
         ext_q        <= T_EXT;
         yel_q        <= T_YEL;
      end else begin
         state_q      <= state_d;
         start_prev_q <= start_timer;
         count_q      <= count_d;
         tr_q         <= tr_d;
         te_q         <= te_d;
         rp_q         <= rp_d;
         base_q       <= base_d;
         ext_q        <= ext_d;
         yel_q        <= yel_d;
      end
   end

   assign time_expired        = te_q;
   assign tiempo_restante     = tr_q;
   assign reprogramSincronico = rp_q;

endmodule

// File: tb/tb_temporizador_intervalos.sv
// Randomized self-checking bench for temporizador_intervalos against a
// duration-table model (expiry at E0 + N*TICK, remaining = N - k/TICK).
module tb_temporizador_intervalos;

   localparam int unsigned DIV = 4;
`ifdef TEMPORIZADOR_FAST_SIM_EN
   localparam int TICK = 1;
`else
   localparam int TICK = DIV;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       start_timer;
   logic [1:0] intervalo;
   logic       prog_we;
   logic [1:0] prog_sel;
   logic [3:0] prog_value;
   logic       time_expired;
   logic [3:0] tiempo_restante;
   logic       reprogramSincronico;

   int checks = 0;
   int errors = 0;
   int tbl[3];

   always #5 clk = ~clk;

   temporizador_intervalos #(
      .DIV   (DIV),
      .T_BASE(4'd6),
      .T_EXT (4'd3),
      .T_YEL (4'd2)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .start_timer        (start_timer),
      .intervalo          (intervalo),
      .prog_we            (prog_we),
      .prog_sel           (prog_sel),
      .prog_value         (prog_value),
      .time_expired       (time_expired),
      .tiempo_restante    (tiempo_restante),
      .reprogramSincronico(reprogramSincronico)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset;
      tbl[0] = 6;
      tbl[1] = 3;
      tbl[2] = 2;
   endtask

   function automatic int dur(input int sel);
      return tbl[(sel == 3) ? 0 : sel];
   endfunction

   // Run with intervalo=sel; abort_at>0 drops the request so it is sampled at E0+abort_at.
   task automatic do_run(input int sel, input int abort_at);
      int n, total, exp_tr;
      logic exp_te;
      n = dur(sel);
      total = n * TICK;
      intervalo = 2'(sel);
      start_timer = 1'b1;
      for (int k = 0; k <= total; k++) begin
         if (abort_at > 0 && k == abort_at) begin
            start_timer = 1'b0;
            step();
            for (int j = 0; j < 3; j++) begin
               checks++;
               if (time_expired !== 1'b0 || tiempo_restante !== 4'd0) begin
                  errors++;
                  $display("FAIL abort sel=%0d k=%0d j=%0d: te=%b tr=%0d, want te=0 tr=0",
                           sel, k, j, time_expired, tiempo_restante);
               end
               step();
            end
            return;
         end
         step();
         exp_te = (k == total);
         exp_tr = (k < total) ? (n - k / TICK) : 0;
         checks++;
         if (time_expired !== exp_te || tiempo_restante !== 4'(exp_tr)) begin
            errors++;
            $display("FAIL run sel=%0d n=%0d k=%0d: te=%b tr=%0d, want te=%b tr=%0d",
                     sel, n, k, time_expired, tiempo_restante, exp_te, exp_tr);
         end
      end
      step();
      checks++;
      if (time_expired !== 1'b1 || tiempo_restante !== 4'd0) begin
         errors++;
         $display("FAIL done_hold sel=%0d: te=%b tr=%0d, want te=1 tr=0",
                  sel, time_expired, tiempo_restante);
      end
      start_timer = 1'b0;
      step();
      checks++;
      if (time_expired !== 1'b0 || tiempo_restante !== 4'd0) begin
         errors++;
         $display("FAIL done_release sel=%0d: te=%b tr=%0d, want te=0 tr=0",
                  sel, time_expired, tiempo_restante);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      start_timer = 1'b0;
      intervalo = 2'b00;
      prog_we = 1'b0;
      prog_sel = 2'b00;
      prog_value = 4'd0;
      model_reset();
      repeat (2) step();
      checks++;
      if (time_expired !== 1'b0 || tiempo_restante !== 4'd0 || reprogramSincronico !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: te=%b tr=%0d rp=%b, want 0 0 0",
                  time_expired, tiempo_restante, reprogramSincronico);
      end
      #2 reset = 1'b0;
      step();
      checks++;
      if (time_expired !== 1'b0 || tiempo_restante !== 4'd0 || reprogramSincronico !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: te=%b tr=%0d rp=%b, want 0 0 0",
                  time_expired, tiempo_restante, reprogramSincronico);
      end
   endtask

   task automatic test_intervals;
      do_run(0, -1);
      do_run(1, -1);
      do_run(2, -1);
      do_run(3, -1);
   endtask

   task automatic test_abort;
      do_run(0, 10);
      do_run(0, -1);
   endtask

   task automatic test_reprogram;
      intervalo = 2'b00;
      start_timer = 1'b1;
      repeat (6) step();
      prog_we = 1'b1;
      prog_sel = 2'b10;
      prog_value = 4'd5;
      step();
      tbl[2] = 5;
      prog_we = 1'b0;
      checks++;
      if (reprogramSincronico !== 1'b1 || time_expired !== 1'b0 || tiempo_restante !== 4'd0) begin
         errors++;
         $display("FAIL reprog_pulse: rp=%b te=%b tr=%0d, want 1 0 0",
                  reprogramSincronico, time_expired, tiempo_restante);
      end
      for (int i = 0; i < 30; i++) begin
         step();
         checks++;
         if (reprogramSincronico !== 1'b0 || time_expired !== 1'b0 || tiempo_restante !== 4'd0) begin
            errors++;
            $display("FAIL reprog_no_restart i=%0d: rp=%b te=%b tr=%0d, want 0 0 0",
                     i, reprogramSincronico, time_expired, tiempo_restante);
         end
      end
      start_timer = 1'b0;
      step();
      do_run(2, -1);
   endtask

   task automatic test_zero_and_ignored;
      prog_we = 1'b1;
      prog_sel = 2'b00;
      prog_value = 4'd0;
      step();
      tbl[0] = 1;
      prog_we = 1'b0;
      checks++;
      if (reprogramSincronico !== 1'b1) begin
         errors++;
         $display("FAIL zero_write_pulse: rp=%b, want 1", reprogramSincronico);
      end
      step();
      checks++;
      if (reprogramSincronico !== 1'b0) begin
         errors++;
         $display("FAIL zero_write_single: rp=%b, want 0", reprogramSincronico);
      end
      do_run(0, -1);
      prog_we = 1'b1;
      prog_sel = 2'b11;
      prog_value = 4'd9;
      step();
      prog_we = 1'b0;
      checks++;
      if (reprogramSincronico !== 1'b0) begin
         errors++;
         $display("FAIL sel11_pulse: rp=%b, want 0", reprogramSincronico);
      end
      do_run(0, -1);
      do_run(3, -1);
   endtask

   task automatic test_back_to_back;
      int s;
      for (int i = 0; i < 3; i++) begin
         s = $urandom_range(0, 2);
         prog_we = 1'b1;
         prog_sel = 2'(s);
         prog_value = 4'($urandom_range(0, 15));
         tbl[s] = (prog_value == 4'd0) ? 1 : int'(prog_value);
         step();
         checks++;
         if (reprogramSincronico !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pulse i=%0d: rp=%b, want 1", i, reprogramSincronico);
         end
      end
      prog_we = 1'b0;
      step();
      checks++;
      if (reprogramSincronico !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end: rp=%b, want 0", reprogramSincronico);
      end
      do_run($urandom_range(0, 3), -1);
   endtask

   task automatic test_async_reset;
      int n;
      n = dur(1);
      intervalo = 2'b01;
      start_timer = 1'b1;
      step();
      checks++;
      if (tiempo_restante !== 4'(n)) begin
         errors++;
         $display("FAIL areset_pre: tr=%0d, want %0d", tiempo_restante, n);
      end
      #1 reset = 1'b1;
      start_timer = 1'b0;
      #1;
      checks++;
      if (time_expired !== 1'b0 || tiempo_restante !== 4'd0 || reprogramSincronico !== 1'b0) begin
         errors++;
         $display("FAIL areset_midrun: te=%b tr=%0d rp=%b, want 0 0 0",
                  time_expired, tiempo_restante, reprogramSincronico);
      end
      #2 reset = 1'b0;
      model_reset();
      step();
      do_run(0, -1);
      // Reset from DONE
      n = dur(2);
      intervalo = 2'b10;
      start_timer = 1'b1;
      repeat (n * TICK + 1) step();
      checks++;
      if (time_expired !== 1'b1) begin
         errors++;
         $display("FAIL areset_pre_done: te=%b, want 1", time_expired);
      end
      #1 reset = 1'b1;
      start_timer = 1'b0;
      #1;
      checks++;
      if (time_expired !== 1'b0 || tiempo_restante !== 4'd0) begin
         errors++;
         $display("FAIL areset_done: te=%b tr=%0d, want 0 0", time_expired, tiempo_restante);
      end
      #2 reset = 1'b0;
      step();
      do_run(1, -1);
   endtask

   task automatic test_random;
      int s, v, ab;
      logic exp_rp;
      for (int i = 0; i < 25; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            s = $urandom_range(0, 3);
            v = $urandom_range(0, 15);
            prog_we = 1'b1;
            prog_sel = 2'(s);
            prog_value = 4'(v);
            exp_rp = (s != 3);
            if (s != 3) tbl[s] = (v == 0) ? 1 : v;
            step();
            prog_we = 1'b0;
            checks++;
            if (reprogramSincronico !== exp_rp) begin
               errors++;
               $display("FAIL rand_write i=%0d sel=%0d: rp=%b, want %b",
                        i, s, reprogramSincronico, exp_rp);
            end
            step();
         end else begin
            s = $urandom_range(0, 3);
            ab = -1;
            if ($urandom_range(0, 3) == 0) ab = $urandom_range(1, dur(s) * TICK);
            do_run(s, ab);
         end
      end
   endtask

   initial begin
      test_reset();
      test_intervals();
      test_abort();
      test_reprogram();
      test_zero_and_ignored();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/temporizador_intervalos.md
# temporizador_intervalos

Interval timer that answers the traffic-light controller's timing requests: it samples the controller's `start_timer`/`intervalo` request, counts the selected duration in seconds and returns `time_expired`. It owns the three programmable durations (base, extension, yellow). Any reprogramming of a duration emits a one-cycle `reprogramSincronico` pulse that restarts the controller in its initial state.

## Interface
- `DIV`, 50_000_000 — clock cycles per second tick; ≥ 2.
- `T_BASE`, 6 — reset value of base duration (seconds, 1..15).
- `T_EXT`, 3 — reset value of extension duration.
- `T_YEL`, 2 — reset value of yellow duration.

- `clk` in 1 — the single clock; rising edge.
- `reset` in 1 — asynchronous, active-high.
- `start_timer` in 1 — level request from the controller; a rising edge starts a run.
- `intervalo` in 2 — duration select: 00 base, 01 extension, 10 yellow, 11 base.
- `prog_we` in 1 — one-cycle write strobe for the duration table.
- `prog_sel` in 2 — duration to write: 00 base, 01 extension, 10 yellow, 11 ignored (no write, no pulse).
- `prog_value` in 4 — new duration in seconds.
- `time_expired` out 1 — registered; high while the run is done and `start_timer` is still high.
- `tiempo_restante` out 4 — registered seconds remaining.
- `reprogramSincronico` out 1 — registered one-cycle pulse after a valid write.

## Operation
- Internal register `start_d` holds the previous `start_timer`. Rise = `start_timer & ~start_d`.
- States:
  - IDLE: `time_expired` = 0 and `tiempo_restante` = 0.
    - On a rise, load `count` = table[`intervalo`] (sampled on that edge) and clear the prescaler.
    - Then go to RUN. `tiempo_restante` = `count`.
  - RUN:
    - Prescaler counts 0..DIV-1.
    - At DIV-1: if `count` == 1, go to DONE and set `time_expired` = 1. Otherwise decrement `count`.
    - If `start_timer` goes low, go to IDLE (abort) and leave `time_expired` = 0.
  - DONE: hold `time_expired` = 1 and `tiempo_restante` = 0. When `start_timer` goes low, go to IDLE and clear `time_expired` on that edge.
- A rise is only recognised in IDLE. A request held high after an abort does not restart the timer; the timer waits for low then high.
- Table write (`prog_we` with `prog_sel` ≠ 11):
  - Store `prog_value`. A value of 0 is stored as 1.
  - Pulse `reprogramSincronico` on the next edge.
  - Force the state to IDLE, clear `time_expired` and clear `count` on the same edge.
  - The write has priority over every other transition on that edge.
- A write and a rise in the same cycle: the write wins and the rise is lost.
- Arithmetic: `count` is 4-bit unsigned and never wraps (minimum 1). The prescaler is `$clog2(DIV)` bits and wraps at DIV-1 to 0.

## Timing
- Reset values:
  - State IDLE.
  - `time_expired` 0, `tiempo_restante` 0, `reprogramSincronico` 0.
  - `start_d` 0, prescaler 0, `count` 0.
  - Table = T_BASE / T_EXT / T_YEL.
- Reset acts immediately, without a clock edge, including mid-run.
- A rise sampled at edge E0 gives `time_expired` = 1 after edge E0 + N·DIV, where N is the stored duration.
- The controller sees `time_expired` one cycle later than that edge (registered output).
- `tiempo_restante` decrements at edges E0 + k·DIV for k = 1..N-1.
- `reprogramSincronico` is high exactly one cycle, at write edge + 1. Back-to-back writes produce back-to-back pulses.

## Configuration
- `TEMPORIZADOR_FAST_SIM_EN` defined: the prescaler is removed and one "second" equals one clock cycle. `time_expired` rises after E0 + N. All other behaviour is unchanged.
- Macro undefined: the DIV-cycle prescaler is active, as specified above.

## Test plan
All scenarios use DIV=4 with the macro undefined unless stated.
- Reset, then raise `start_timer` with `intervalo`=00 → `time_expired` rises after E0+24. `tiempo_restante` steps 6,5,4,3,2,1 every 4 cycles, then reads 0 in DONE. Dropping `start_timer` clears `time_expired` on the next edge.
- Runs with `intervalo`=01 / 10 / 11 → expiry at E0+12 / E0+8 / E0+24.
- Drop `start_timer` at E0+10 of a base run → no `time_expired`, `tiempo_restante` = 0, state IDLE. A following rise gives a full 24-cycle run.
- `prog_we`, `prog_sel`=10, `prog_value`=5 mid-run with `start_timer` held high:
  - `reprogramSincronico` pulses one cycle, the run aborts and no restart occurs while the request stays high.
  - After low then high with `intervalo`=10 → expiry at E0+20.
- `prog_value`=0 to base → next base run expires at E0+4. A write with `prog_sel`=11 → no pulse and no change.
- Assert `reset` asynchronously mid-run → all outputs 0 before the next edge and the table is restored. Rebuilt with `TEMPORIZADOR_FAST_SIM_EN` → a base run expires at E0+6.
